// File: rtl/decode_stage.sv
// Instruction decode stage feeding the register file. Decodes a 9-bit
// instruction, registers the fields behind a valid/ready output stage,
// stalls on RAW hazards against an outstanding writeback and latches HALT.
module decode_stage #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [8:0]        in_instr,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        rs1,
  output logic [2:0]        rs2,
  output logic [2:0]        rd,
  output logic              reg_write,
  output logic              label_write,
  output logic              label_read,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] imm,
  input  logic              wb_pending,
  input  logic [2:0]        wb_rd,
  input  logic              wb_label,
  output logic              halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state, state_next;

  logic [2:0] opcode;
  logic [2:0] f_hi;
  logic [2:0] f_lo;
  logic       is_alu;
  logic       is_br;
  logic       is_halt;
  logic       stall;
  logic       accept;

  logic [2:0]        d_rs1;
  logic [2:0]        d_rs2;
  logic [2:0]        d_rd;
  logic              d_reg_write;
  logic              d_label_write;
  logic              d_label_read;
  logic [1:0]        d_alu_op;
  logic [DATA_W-1:0] d_imm;

  assign opcode  = in_instr[8:6];
  assign f_hi    = in_instr[5:3];
  assign f_lo    = in_instr[2:0];
  assign is_alu  = (opcode[2] == 1'b0);
  assign is_br   = (opcode == 3'b110);
  assign is_halt = (opcode == 3'b111);

  // RAW hazard: ALU sources live in the general bank, BR source in the label bank
  always_comb begin
    stall = 1'b0;
    if (HAZARD_EN && wb_pending) begin
      if (is_alu && !wb_label && ((wb_rd == f_hi) || (wb_rd == f_lo)))
        stall = 1'b1;
      else if (is_br && wb_label && (wb_rd == f_hi))
        stall = 1'b1;
    end
  end

  // Handshake: accept only in RUN, outside reset, unstalled, with room downstream
  always_comb begin
    in_ready = rst_n && (state == RUN) && !stall && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  // Field decode; unused fields stay zero, HALT decodes to all-zero flags
  always_comb begin
    d_rs1         = '0;
    d_rs2         = '0;
    d_rd          = '0;
    d_reg_write   = 1'b0;
    d_label_write = 1'b0;
    d_label_read  = 1'b0;
    d_alu_op      = '0;
    d_imm         = '0;
    case (opcode)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        d_rs1       = f_hi;
        d_rd        = f_hi;
        d_rs2       = f_lo;
        d_reg_write = 1'b1;
        d_alu_op    = opcode[1:0];
      end
      3'b100: begin
        d_rd        = f_hi;
        d_imm       = DATA_W'(f_lo);
        d_reg_write = 1'b1;
      end
      3'b101: begin
        d_rd          = f_hi;
        d_imm         = DATA_W'(f_lo);
        d_label_write = 1'b1;
      end
      3'b110: begin
        d_rs1        = f_hi;
        d_label_read = 1'b1;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Next state: HALT is entered when a HALT instruction is accepted and never left
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept && is_halt) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  assign halted = (state == HALT);

  // Output register: load on accept, drop valid on drain without a new accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      reg_write   <= 1'b0;
      label_write <= 1'b0;
      label_read  <= 1'b0;
      alu_op      <= '0;
      imm         <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      rs1         <= d_rs1;
      rs2         <= d_rs2;
      rd          <= d_rd;
      reg_write   <= d_reg_write;
      label_write <= d_label_write;
      label_read  <= d_label_read;
      alu_op      <= d_alu_op;
      imm         <= d_imm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [8:0] in_instr;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] rs1, rs2, rd;
  logic       reg_write, label_write, label_read;
  logic [1:0] alu_op;
  logic [7:0] imm;
  logic       wb_pending;
  logic [2:0] wb_rd;
  logic       wb_label;
  logic       halted;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [22:0] obs_out;

  decode_stage #(.DATA_W(8), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .label_write(label_write), .label_read(label_read),
    .alu_op(alu_op), .imm(imm),
    .wb_pending(wb_pending), .wb_rd(wb_rd), .wb_label(wb_label),
    .halted(halted)
  );

  always #5 clk = ~clk;

  assign obs_out = {out_valid, rs1, rs2, rd, reg_write, label_write, label_read, alu_op, imm};

  function automatic logic [22:0] pk(input logic v, input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] d, input logic rw, input logic lw,
                                     input logic lr, input logic [1:0] op, input logic [7:0] im);
    return {v, a, b, d, rw, lw, lr, op, im};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_pending = 1'b0; wb_rd = '0; wb_label = 1'b0;

    step(); step();
    chk("rst_outputs", 32'(obs_out), 32'(pk(0,0,0,0,0,0,0,0,0)));
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    rst_n = 1'b1; #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // stream: ADD r2,r3 then SUB r4,r5 back to back
    in_valid = 1'b1; in_instr = 9'b000_010_011; out_ready = 1'b1;
    step();
    chk("add_out", 32'(obs_out), 32'(pk(1,2,3,2,1,0,0,2'b00,0)));
    in_instr = 9'b001_100_101; #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("sub_out", 32'(obs_out), 32'(pk(1,4,5,4,1,0,0,2'b01,0)));

    // backpressure: AND offered while downstream stalled
    out_ready = 1'b0; in_instr = 9'b010_001_010; #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("bp_hold", 32'(obs_out), 32'(pk(1,4,5,4,1,0,0,2'b01,0)));
    out_ready = 1'b1; #1;
    chk("drain_accept_ready", 32'(in_ready), 32'd1);
    step();
    chk("and_out", 32'(obs_out), 32'(pk(1,1,2,1,1,0,0,2'b10,0)));

    // drain without a new accept
    in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // hazard on ALU rs2 against general-bank writeback
    in_valid = 1'b1; in_instr = 9'b000_001_011;
    wb_pending = 1'b1; wb_rd = 3'd3; wb_label = 1'b0; #1;
    chk("haz_alu_stall", 32'(in_ready), 32'd0);
    step();
    chk("haz_no_accept", 32'(out_valid), 32'd0);
    wb_label = 1'b1; #1;
    chk("haz_bank_mismatch", 32'(in_ready), 32'd1);
    wb_label = 1'b0; wb_pending = 1'b0; #1;
    chk("haz_clear_ready", 32'(in_ready), 32'd1);
    step();
    chk("haz_add_out", 32'(obs_out), 32'(pk(1,1,3,1,1,0,0,2'b00,0)));

    // SHL
    in_instr = 9'b011_111_000;
    step();
    chk("shl_out", 32'(obs_out), 32'(pk(1,7,0,7,1,0,0,2'b11,0)));

    // LBL rd=5 imm=6
    in_instr = 9'b101_101_110;
    step();
    chk("lbl_out", 32'(obs_out), 32'(pk(1,0,0,5,0,1,0,2'b00,8'h06)));

    // LI rd=3 imm=7
    in_instr = 9'b100_011_111;
    step();
    chk("li_out", 32'(obs_out), 32'(pk(1,0,0,3,1,0,0,2'b00,8'h07)));

    // BR rs1=5 against label-bank writeback to 5
    in_instr = 9'b110_101_000; wb_pending = 1'b1; wb_rd = 3'd5; wb_label = 1'b1; #1;
    chk("br_stall", 32'(in_ready), 32'd0);
    wb_label = 1'b0; #1;
    chk("br_general_no_stall", 32'(in_ready), 32'd1);
    step();
    chk("br_out", 32'(obs_out), 32'(pk(1,5,0,0,0,0,1,2'b00,0)));
    wb_pending = 1'b0;

    // HALT
    in_instr = 9'b111_000_000;
    step();
    chk("halt_out", 32'(obs_out), 32'(pk(1,0,0,0,0,0,0,2'b00,0)));
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_in_ready", 32'(in_ready), 32'd0);
    in_instr = 9'b000_010_011;
    step(); step(); step();
    chk("halt_ignore_valid", 32'(out_valid), 32'd0);
    chk("halt_ignore_fields", 32'(obs_out), 32'(pk(0,0,0,0,0,0,0,2'b00,0)));
    chk("halt_sticky_ready", 32'(in_ready), 32'd0);
    chk("halt_sticky", 32'(halted), 32'd1);

    // reset mid-operation after reloading an instruction
    rst_n = 1'b0; #1;
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; #1;
    chk("rst2_release_ready", 32'(in_ready), 32'd1);
    step();
    chk("rst2_add_out", 32'(obs_out), 32'(pk(1,2,3,2,1,0,0,2'b00,0)));
    rst_n = 1'b0; #1;
    chk("rst_async_drop", 32'(obs_out), 32'(pk(0,0,0,0,0,0,0,0,0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
